// File: rtl/dma_copy.sv
// Block-copy DMA between the CPU bus and RAM, programmed through a 16-byte register window.
// Latency: START in cycle T -> cpu_RDY low T+1..T+2L+1, bus returned at T+2L+2 (2 cycles/byte).
// Backpressure: none accepted; the engine stalls the CPU with cpu_RDY while it owns the RAM bus.
module dma_copy #(
    parameter logic [23:0] REG_BASE = 24'hFFFFE0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [23:0] cpu_AB,
    input  logic [7:0]  cpu_DO,
    input  logic        cpu_WE,
    output logic [7:0]  cpu_DI,
    output logic        cpu_RDY,
    output logic [23:0] AB,
    output logic [7:0]  DO,
    output logic        WE,
    input  logic [7:0]  DI,
    output logic        irq,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_READ   = 2'd1,
        ST_WRITE  = 2'd2,
        ST_RESUME = 2'd3
    } state_t;

    localparam logic [3:0] OFF_SRC0 = 4'h0;
    localparam logic [3:0] OFF_SRC1 = 4'h1;
    localparam logic [3:0] OFF_SRC2 = 4'h2;
    localparam logic [3:0] OFF_DST0 = 4'h3;
    localparam logic [3:0] OFF_DST1 = 4'h4;
    localparam logic [3:0] OFF_DST2 = 4'h5;
    localparam logic [3:0] OFF_LEN0 = 4'h6;
    localparam logic [3:0] OFF_LEN1 = 4'h7;
    localparam logic [3:0] OFF_CTRL = 4'h8;

    state_t      state_q, state_d;
    logic [23:0] src_q, src_d;
    logic [23:0] dst_q, dst_d;
    logic [15:0] len_q, len_d;
    logic        ie_q, ie_d;
    logic        done_q, done_d;
    logic        sel_q, sel_d;
    logic [7:0]  rdata_q, rdata_d;

    logic        in_win;
    logic [3:0]  reg_off;
    logic        reg_wr;
    logic [7:0]  reg_rdata;

    // Window decode: upper 20 address bits select the register block.
    always_comb begin
        in_win  = (cpu_AB[23:4] == REG_BASE[23:4]);
        reg_off = cpu_AB[3:0];
        // Register writes only land while the CPU owns the bus.
        reg_wr  = (state_q == ST_IDLE) && cpu_WE && in_win;
    end

    // Register read mux; START always reads back as 0, unused offsets read 00.
    always_comb begin
        reg_rdata = 8'h00;
        case (reg_off)
            OFF_SRC0: reg_rdata = src_q[7:0];
            OFF_SRC1: reg_rdata = src_q[15:8];
            OFF_SRC2: reg_rdata = src_q[23:16];
            OFF_DST0: reg_rdata = dst_q[7:0];
            OFF_DST1: reg_rdata = dst_q[15:8];
            OFF_DST2: reg_rdata = dst_q[23:16];
            OFF_LEN0: reg_rdata = len_q[7:0];
            OFF_LEN1: reg_rdata = len_q[15:8];
            OFF_CTRL: reg_rdata = {done_q, 5'b00000, ie_q, 1'b0};
            default:  reg_rdata = 8'h00;
        endcase
    end

    // Next-state logic: register writes, START decode and copy address/length stepping.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        len_d   = len_q;
        ie_d    = ie_q;
        done_d  = done_q;
        // Read capture mirrors the RAM's one-cycle registered read.
        sel_d   = in_win;
        rdata_d = reg_rdata;

        unique case (state_q)
            ST_IDLE: begin
                if (reg_wr) begin
                    case (reg_off)
                        OFF_SRC0: src_d[7:0]   = cpu_DO;
                        OFF_SRC1: src_d[15:8]  = cpu_DO;
                        OFF_SRC2: src_d[23:16] = cpu_DO;
                        OFF_DST0: dst_d[7:0]   = cpu_DO;
                        OFF_DST1: dst_d[15:8]  = cpu_DO;
                        OFF_DST2: dst_d[23:16] = cpu_DO;
                        OFF_LEN0: len_d[7:0]   = cpu_DO;
                        OFF_LEN1: len_d[15:8]  = cpu_DO;
                        OFF_CTRL: begin
                            ie_d = cpu_DO[1];
                            if (cpu_DO[7]) begin
                                done_d = 1'b0;
                            end
                            // A zero-length start completes at once without touching the bus.
                            if (cpu_DO[0]) begin
                                if (len_q != 16'h0000) begin
                                    state_d = ST_READ;
                                end else begin
                                    done_d = 1'b1;
                                end
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_READ: begin
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                // Addresses wrap naturally at 24 bits.
                src_d = src_q + 24'd1;
                dst_d = dst_q + 24'd1;
                len_d = len_q - 16'd1;
                if (len_q == 16'd1) begin
                    done_d  = 1'b1;
                    state_d = ST_RESUME;
                end else begin
                    state_d = ST_READ;
                end
            end
            ST_RESUME: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Bus steering: CPU passes through in IDLE, engine drives the RAM otherwise.
    always_comb begin
        AB      = cpu_AB;
        DO      = cpu_DO;
        WE      = 1'b0;
        cpu_RDY = 1'b1;
        busy    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                // Register-window writes must never reach the RAM.
                WE = cpu_WE && !in_win;
            end
            ST_READ: begin
                AB      = src_q;
                cpu_RDY = 1'b0;
                busy    = 1'b1;
            end
            ST_WRITE: begin
                AB      = dst_q;
                DO      = DI;
                WE      = 1'b1;
                cpu_RDY = 1'b0;
                busy    = 1'b1;
            end
            ST_RESUME: begin
                // Re-present the held CPU address so the RAM output matches it again.
                AB      = cpu_AB;
                cpu_RDY = 1'b0;
                busy    = 1'b1;
            end
            default: ;
        endcase
    end

    // CPU read data and interrupt level.
    always_comb begin
        cpu_DI = sel_q ? rdata_q : DI;
        irq    = done_q & ie_q;
    end

    // State register; async reset returns everything to a clean idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            src_q   <= 24'h000000;
            dst_q   <= 24'h000000;
            len_q   <= 16'h0000;
            ie_q    <= 1'b0;
            done_q  <= 1'b0;
            sel_q   <= 1'b0;
            rdata_q <= 8'h00;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            ie_q    <= ie_d;
            done_q  <= done_d;
            sel_q   <= sel_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: tb/tb_dma_copy.sv
// Directed bench for dma_copy with a registered-read RAM model.
// Latency: checks exact stall lengths and one-cycle read latency.
// Backpressure: CPU side is stalled by cpu_RDY; the RAM model never stalls.
module tb_dma_copy;

    localparam logic [23:0] BASE = 24'hFFFFE0;
    localparam logic [23:0] IDLE_ADDR = 24'h00F000;

    logic        clk;
    logic        reset;
    logic [23:0] cpu_AB;
    logic [7:0]  cpu_DO;
    logic        cpu_WE;
    logic [7:0]  cpu_DI;
    logic        cpu_RDY;
    logic [23:0] AB;
    logic [7:0]  DO;
    logic        WE;
    logic [7:0]  DI;
    logic        irq;
    logic        busy;

    int tests;
    int fails;
    int rdy_low;
    int we_cnt;

    logic [7:0] mem [bit [23:0]];

    dma_copy #(.REG_BASE(BASE)) dut (
        .clk(clk), .reset(reset),
        .cpu_AB(cpu_AB), .cpu_DO(cpu_DO), .cpu_WE(cpu_WE), .cpu_DI(cpu_DI), .cpu_RDY(cpu_RDY),
        .AB(AB), .DO(DO), .WE(WE), .DI(DI), .irq(irq), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] mem_rd(input logic [23:0] a);
        if (mem.exists(a)) return mem[a];
        return 8'h00;
    endfunction

    // Registered-read RAM: DI returns the old contents of the addressed byte.
    always @(posedge clk) begin
        DI <= mem_rd(AB);
        if (WE) mem[AB] = DO;
    end

    // Activity monitors sampled mid-cycle.
    always @(negedge clk) begin
        if (!reset) begin
            if (!cpu_RDY) rdy_low = rdy_low + 1;
            if (WE) we_cnt = we_cnt + 1;
        end
    end

    task automatic cpu_write(input logic [23:0] a, input logic [7:0] d);
        @(negedge clk);
        cpu_AB = a;
        cpu_DO = d;
        cpu_WE = 1'b1;
        @(negedge clk);
        cpu_WE = 1'b0;
        cpu_AB = IDLE_ADDR;
    endtask

    task automatic cpu_read(input logic [23:0] a, output logic [7:0] d);
        @(negedge clk);
        cpu_AB = a;
        cpu_WE = 1'b0;
        @(negedge clk);
        d = cpu_DI;
        cpu_AB = IDLE_ADDR;
    endtask

    task automatic program_regs(input logic [23:0] s, input logic [23:0] t, input logic [15:0] n);
        cpu_write(BASE + 24'd0, s[7:0]);
        cpu_write(BASE + 24'd1, s[15:8]);
        cpu_write(BASE + 24'd2, s[23:16]);
        cpu_write(BASE + 24'd3, t[7:0]);
        cpu_write(BASE + 24'd4, t[15:8]);
        cpu_write(BASE + 24'd5, t[23:16]);
        cpu_write(BASE + 24'd6, n[7:0]);
        cpu_write(BASE + 24'd7, n[15:8]);
    endtask

    task automatic test_reset();
        logic [7:0] r;
        #1;
        tests++;
        if (cpu_RDY !== 1'b1 || WE !== 1'b0 || irq !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs: rdy=%b we=%b irq=%b busy=%b, need 1 0 0 0", cpu_RDY, WE, irq, busy);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        cpu_read(BASE + 24'd8, r);
        tests++;
        if (r !== 8'h00) begin fails++; $display("FAIL reset_ctrl: got %h need 00", r); end
        cpu_read(BASE + 24'd0, r);
        tests++;
        if (r !== 8'h00) begin fails++; $display("FAIL reset_src0: got %h need 00", r); end
    endtask

    task automatic test_basic_copy();
        logic [7:0] r;
        mem[24'h000100] = 8'h11; mem[24'h000101] = 8'h22;
        mem[24'h000102] = 8'h33; mem[24'h000103] = 8'h44;
        program_regs(24'h000100, 24'h000200, 16'd4);
        rdy_low = 0; we_cnt = 0;
        cpu_write(BASE + 24'd8, 8'h01);
        tests++;
        if (cpu_RDY !== 1'b0 || busy !== 1'b1) begin
            fails++; $display("FAIL copy_stall_start: rdy=%b busy=%b need 0 1", cpu_RDY, busy);
        end
        repeat (20) @(negedge clk);
        tests++;
        if (rdy_low !== 9) begin fails++; $display("FAIL copy_rdy_low: got %0d cycles need 9", rdy_low); end
        tests++;
        if (we_cnt !== 4) begin fails++; $display("FAIL copy_we_pulses: got %0d need 4", we_cnt); end
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (mem_rd(24'h000200 + 24'(i)) !== mem_rd(24'h000100 + 24'(i))) begin
                fails++;
                $display("FAIL copy_data[%0d]: got %h need %h", i, mem_rd(24'h000200 + 24'(i)), mem_rd(24'h000100 + 24'(i)));
            end
        end
        tests++;
        if (mem_rd(24'h000203) !== 8'h44) begin fails++; $display("FAIL copy_last: got %h need 44", mem_rd(24'h000203)); end
        cpu_read(BASE + 24'd8, r);
        tests++;
        if (r !== 8'h80) begin fails++; $display("FAIL copy_done: ctrl %h need 80", r); end
        cpu_read(BASE + 24'd0, r);
        tests++;
        if (r !== 8'h04) begin fails++; $display("FAIL copy_src0: got %h need 04", r); end
        cpu_read(BASE + 24'd1, r);
        tests++;
        if (r !== 8'h01) begin fails++; $display("FAIL copy_src1: got %h need 01", r); end
        cpu_read(BASE + 24'd6, r);
        tests++;
        if (r !== 8'h00) begin fails++; $display("FAIL copy_len0: got %h need 00", r); end
        cpu_read(BASE + 24'd7, r);
        tests++;
        if (r !== 8'h00) begin fails++; $display("FAIL copy_len1: got %h need 00", r); end
    endtask

    task automatic test_zero_len_irq();
        logic [7:0] r;
        cpu_write(BASE + 24'd8, 8'h80);
        cpu_read(BASE + 24'd8, r);
        tests++;
        if (r !== 8'h00) begin fails++; $display("FAIL zl_clear_first: ctrl %h need 00", r); end
        rdy_low = 0; we_cnt = 0;
        cpu_write(BASE + 24'd8, 8'h01);
        tests++;
        if (cpu_RDY !== 1'b1 || busy !== 1'b0) begin
            fails++; $display("FAIL zl_no_stall: rdy=%b busy=%b need 1 0", cpu_RDY, busy);
        end
        cpu_read(BASE + 24'd8, r);
        tests++;
        if (r !== 8'h80) begin fails++; $display("FAIL zl_done: ctrl %h need 80", r); end
        repeat (4) @(negedge clk);
        tests++;
        if (we_cnt !== 0 || rdy_low !== 0) begin
            fails++; $display("FAIL zl_bus_quiet: we=%0d rdy_low=%0d need 0 0", we_cnt, rdy_low);
        end
        tests++;
        if (irq !== 1'b0) begin fails++; $display("FAIL zl_irq_masked: got %b need 0", irq); end
        cpu_write(BASE + 24'd8, 8'h02);
        tests++;
        if (irq !== 1'b1) begin fails++; $display("FAIL zl_irq_raise: got %b need 1", irq); end
        cpu_write(BASE + 24'd8, 8'h82);
        tests++;
        if (irq !== 1'b0) begin fails++; $display("FAIL zl_irq_clear: got %b need 0", irq); end
        cpu_read(BASE + 24'd8, r);
        tests++;
        if (r !== 8'h02) begin fails++; $display("FAIL zl_ctrl_after: ctrl %h need 02", r); end
        cpu_write(BASE + 24'd8, 8'h00);
    endtask

    task automatic test_wrap();
        logic [7:0] r;
        mem[24'h01FFFF] = 8'h5C;
        mem[24'h020000] = 8'hC5;
        program_regs(24'h01FFFF, 24'h000010, 16'd2);
        cpu_write(BASE + 24'd8, 8'h01);
        repeat (10) @(negedge clk);
        tests++;
        if (mem_rd(24'h000010) !== 8'h5C || mem_rd(24'h000011) !== 8'hC5) begin
            fails++; $display("FAIL wrap_src_data: got %h %h need 5c c5", mem_rd(24'h000010), mem_rd(24'h000011));
        end
        cpu_read(BASE + 24'd2, r);
        tests++;
        if (r !== 8'h02) begin fails++; $display("FAIL wrap_src2: got %h need 02", r); end
        cpu_read(BASE + 24'd0, r);
        tests++;
        if (r !== 8'h01) begin fails++; $display("FAIL wrap_src0: got %h need 01", r); end
        program_regs(24'h000010, 24'hFFFFFF, 16'd2);
        cpu_write(BASE + 24'd8, 8'h81);
        repeat (10) @(negedge clk);
        tests++;
        if (mem_rd(24'h000000) !== 8'hC5) begin fails++; $display("FAIL wrap_dst_data: got %h need c5", mem_rd(24'h000000)); end
        cpu_read(BASE + 24'd3, r);
        tests++;
        if (r !== 8'h01) begin fails++; $display("FAIL wrap_dst0: got %h need 01", r); end
        cpu_read(BASE + 24'd5, r);
        tests++;
        if (r !== 8'h00) begin fails++; $display("FAIL wrap_dst2: got %h need 00", r); end
    endtask

    task automatic test_overlap();
        mem[24'h000300] = 8'hAA; mem[24'h000301] = 8'h01;
        mem[24'h000302] = 8'h02; mem[24'h000303] = 8'h03;
        program_regs(24'h000300, 24'h000301, 16'd3);
        cpu_write(BASE + 24'd8, 8'h81);
        repeat (12) @(negedge clk);
        for (int i = 1; i < 4; i++) begin
            tests++;
            if (mem_rd(24'h000300 + 24'(i)) !== 8'hAA) begin
                fails++; $display("FAIL overlap[%0d]: got %h need aa", i, mem_rd(24'h000300 + 24'(i)));
            end
        end
    endtask

    task automatic test_reset_mid_copy();
        logic [7:0] r;
        for (int i = 0; i < 5; i++) begin
            mem[24'h000400 + 24'(i)] = 8'(i + 1);
            mem[24'h000500 + 24'(i)] = 8'hEE;
        end
        program_regs(24'h000400, 24'h000500, 16'd5);
        cpu_write(BASE + 24'd8, 8'h81);
        repeat (5) @(negedge clk);
        tests++;
        if (WE !== 1'b1 || AB !== 24'h000502) begin
            fails++; $display("FAIL rst_mid_phase: we=%b ab=%h need 1 000502", WE, AB);
        end
        reset = 1'b1;
        #1;
        tests++;
        if (cpu_RDY !== 1'b1 || WE !== 1'b0 || busy !== 1'b0 || irq !== 1'b0) begin
            fails++; $display("FAIL rst_mid_outputs: rdy=%b we=%b busy=%b irq=%b need 1 0 0 0", cpu_RDY, WE, busy, irq);
        end
        @(negedge clk);
        reset = 1'b0;
        tests++;
        if (mem_rd(24'h000500) !== 8'h01 || mem_rd(24'h000501) !== 8'h02) begin
            fails++; $display("FAIL rst_mid_copied: got %h %h need 01 02", mem_rd(24'h000500), mem_rd(24'h000501));
        end
        for (int i = 2; i < 5; i++) begin
            tests++;
            if (mem_rd(24'h000500 + 24'(i)) !== 8'hEE) begin
                fails++; $display("FAIL rst_mid_untouched[%0d]: got %h need ee", i, mem_rd(24'h000500 + 24'(i)));
            end
        end
        cpu_read(BASE + 24'd0, r);
        tests++;
        if (r !== 8'h00) begin fails++; $display("FAIL rst_mid_src0: got %h need 00", r); end
        cpu_read(BASE + 24'd6, r);
        tests++;
        if (r !== 8'h00) begin fails++; $display("FAIL rst_mid_len0: got %h need 00", r); end
    endtask

    task automatic test_reg_window();
        logic [7:0] r;
        mem[BASE + 24'd3] = 8'h77;
        mem[BASE + 24'd9] = 8'h66;
        mem[24'h001234] = 8'h9C;
        we_cnt = 0;
        cpu_write(BASE + 24'd3, 8'h5A);
        cpu_write(BASE + 24'd9, 8'hFF);
        tests++;
        if (we_cnt !== 0) begin fails++; $display("FAIL win_we_blocked: got %0d pulses need 0", we_cnt); end
        @(negedge clk);
        cpu_AB = BASE + 24'd3;
        @(negedge clk);
        tests++;
        if (cpu_DI !== 8'h5A) begin fails++; $display("FAIL win_read_dst0: got %h need 5a", cpu_DI); end
        cpu_AB = IDLE_ADDR;
        tests++;
        if (mem_rd(BASE + 24'd3) !== 8'h77) begin fails++; $display("FAIL win_ram_intact: got %h need 77", mem_rd(BASE + 24'd3)); end
        cpu_read(BASE + 24'd9, r);
        tests++;
        if (r !== 8'h00) begin fails++; $display("FAIL win_unused_off: got %h need 00", r); end
        cpu_read(24'h001234, r);
        tests++;
        if (r !== 8'h9C) begin fails++; $display("FAIL win_ram_passthru: got %h need 9c", r); end
        cpu_write(24'h001235, 8'h3D);
        tests++;
        if (mem_rd(24'h001235) !== 8'h3D) begin fails++; $display("FAIL win_ram_write: got %h need 3d", mem_rd(24'h001235)); end
    endtask

    initial begin
        tests = 0; fails = 0; rdy_low = 0; we_cnt = 0;
        reset = 1'b1;
        cpu_AB = IDLE_ADDR;
        cpu_DO = 8'h00;
        cpu_WE = 1'b0;
        test_reset();
        test_basic_copy();
        test_zero_len_irq();
        test_wrap();
        test_overlap();
        test_reset_mid_copy();
        test_reg_window();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
